// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter.
// Holds the arbiter state encoding and default timing.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY
  } arb_state_t;

  localparam int START_TIMEOUT_DEF = 64;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: rotate, priority-encode, unrotate.
// Purely combinational; Win_Vld is high when any request is set.
module uart_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  Req,
  input  logic [IW-1:0] Rr_Ptr,
  output logic [IW-1:0] Win_Id,
  output logic          Win_Vld
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;

  assign dbl = {Req, Req} >> Rr_Ptr;
  assign rot = dbl[N-1:0];

  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    sum = {1'b0, off} + {1'b0, Rr_Ptr};
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    Win_Id  = sum[IW-1:0];
    Win_Vld = |Req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte sources.
// Round-robin grant, start handshake with timeout, frame wait.
import uart_pkg::*;

module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_BITS     = 8,
  parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [NUM_REQ-1:0]           Req,
  input  logic [NUM_REQ*DATA_BITS-1:0] Req_Data,
  output logic [NUM_REQ-1:0]           Ack,
  input  logic                         CTS,
  output logic [DATA_BITS-1:0]         Tx_Data,
  output logic                         Transmit_Start,
  input  logic                         Tx_Busy,
  output logic [$clog2(NUM_REQ)-1:0]   Grant_Id,
  output logic                         Arb_Busy,
  output logic                         Timeout_Err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(START_TIMEOUT);

  arb_state_t state, state_d;
  logic [IW-1:0] rr_ptr, ptr_d, ptr_nxt;
  logic [CW-1:0] cnt, cnt_d;
  logic [DATA_BITS-1:0] data_d;
  logic [NUM_REQ-1:0] ack_d;
  logic [IW-1:0] gid_d, pick_id;
  logic start_d, busy_d, to_d, pick_vld;
  logic [DATA_BITS-1:0] slot [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slot
    assign slot[k] = Req_Data[k*DATA_BITS +: DATA_BITS];
  end

  uart_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .Req     (Req),
    .Rr_Ptr  (rr_ptr),
    .Win_Id  (pick_id),
    .Win_Vld (pick_vld)
  );

  assign ptr_nxt = (Grant_Id == IW'(NUM_REQ - 1)) ?
                   '0 : Grant_Id + 1'b1;

  always_comb begin
    state_d = state;
    ptr_d   = rr_ptr;
    cnt_d   = cnt;
    data_d  = Tx_Data;
    gid_d   = Grant_Id;
    ack_d   = '0;
    start_d = 1'b0;
    busy_d  = 1'b1;
    to_d    = 1'b0;
    unique case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (CTS && !Tx_Busy && pick_vld) begin
          state_d = START;
          data_d  = slot[pick_id];
          gid_d   = pick_id;
          cnt_d   = '0;
          start_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      START: begin
        // A dead requester must not keep the pointer, so advance on timeout too.
        if (Tx_Busy) begin
          state_d = BUSY;
          ptr_d   = ptr_nxt;
          ack_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << Grant_Id;
        end else if (cnt == CW'(START_TIMEOUT - 1)) begin
          state_d = IDLE;
          ptr_d   = ptr_nxt;
          to_d    = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d   = cnt + 1'b1;
          start_d = 1'b1;
        end
      end
      BUSY: begin
        if (!Tx_Busy) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      cnt            <= '0;
      Tx_Data        <= '0;
      Transmit_Start <= 1'b0;
      Ack            <= '0;
      Grant_Id       <= '0;
      Arb_Busy       <= 1'b0;
      Timeout_Err    <= 1'b0;
    end else begin
      state          <= state_d;
      rr_ptr         <= ptr_d;
      cnt            <= cnt_d;
      Tx_Data        <= data_d;
      Transmit_Start <= start_d;
      Ack            <= ack_d;
      Grant_Id       <= gid_d;
      Arb_Busy       <= busy_d;
      Timeout_Err    <= to_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a small UART model.
// Expected grants are queued at stimulus time and popped on each start.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DB = 8;
  localparam int TO = 8;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [N-1:0]  Req;
  logic [N*DB-1:0] Req_Data;
  logic [N-1:0]  Ack;
  logic          CTS;
  logic [DB-1:0] Tx_Data;
  logic          Transmit_Start;
  logic          Tx_Busy;
  logic [1:0]    Grant_Id;
  logic          Arb_Busy;
  logic          Timeout_Err;

  logic mbusy = 1'b0;
  logic force_busy = 1'b0;
  logic uart_en = 1'b1;
  int   busy_delay = 2;
  int   frame_len = 4;
  int   sc = 0;
  int   fc = 0;

  assign Tx_Busy = mbusy | force_busy;

  typedef struct packed {
    logic [1:0]    id;
    logic [DB-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int tests = 0;
  int fails = 0;
  int ack_cnt = 0;
  int to_cnt = 0;
  int start_cnt = 0;
  int st_len = 0;
  int st_len_last = 0;
  logic prev_st = 1'b0;
  logic [1:0] cur_id = '0;
  bit drop_on_ack = 1'b1;
  int base;
  int s;

  uart_tx_arbiter #(
    .NUM_REQ(N), .DATA_BITS(DB), .START_TIMEOUT(TO)
  ) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .Req            (Req),
    .Req_Data       (Req_Data),
    .Ack            (Ack),
    .CTS            (CTS),
    .Tx_Data        (Tx_Data),
    .Transmit_Start (Transmit_Start),
    .Tx_Busy        (Tx_Busy),
    .Grant_Id       (Grant_Id),
    .Arb_Busy       (Arb_Busy),
    .Timeout_Err    (Timeout_Err)
  );

  initial forever #10 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id);
    exp_t e;
    e.id   = id[1:0];
    e.data = Req_Data[id*DB +: DB];
    sb.push_back(e);
  endtask

  task automatic tick();
    @(negedge Clk);
    #1;
    if (drop_on_ack && Ack != '0) Req = Req & ~Ack;
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_acks(input int n, input int budget,
                           input string tag);
    int t = 0;
    while (ack_cnt < n && t < budget) begin
      tick();
      t++;
    end
    chk(tag, ack_cnt, n);
  endtask

  task automatic wait_to(input int n, input int budget);
    int t = 0;
    while (to_cnt < n && t < budget) begin
      tick();
      t++;
    end
    chk("to_seen", to_cnt, n);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (Arb_Busy && t < 40) begin
      tick();
      t++;
    end
    chk(tag, Arb_Busy, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_start"}, Transmit_Start, 0);
    chk({tag, "_ack"}, Ack, 0);
    chk({tag, "_data"}, Tx_Data, 0);
    chk({tag, "_gid"}, Grant_Id, 0);
    chk({tag, "_busy"}, Arb_Busy, 0);
    chk({tag, "_to"}, Timeout_Err, 0);
  endtask

  // UART model: takes the start after busy_delay cycles, then stays busy.
  initial forever begin
    @(negedge Clk);
    if (mbusy) begin
      fc++;
      if (fc >= frame_len) mbusy = 1'b0;
    end else if (uart_en && Transmit_Start) begin
      sc++;
      if (sc >= busy_delay) begin
        mbusy = 1'b1;
        fc = 0;
        sc = 0;
      end
    end else begin
      sc = 0;
    end
  end

  initial forever begin
    @(negedge Clk);
    if (Transmit_Start) begin
      if (!prev_st) begin
        start_cnt++;
        st_len = 0;
        chk("arb_busy", Arb_Busy, 1);
        if (sb.size() == 0) begin
          chk("sb_empty", 32'(sb.size()), 1);
        end else begin
          mon_e = sb.pop_front();
          cur_id = mon_e.id;
          chk("grant_id", Grant_Id, mon_e.id);
          chk("tx_data", Tx_Data, mon_e.data);
        end
      end
      st_len++;
    end else if (prev_st) begin
      st_len_last = st_len;
    end
    prev_st = Transmit_Start;
    if (Ack != '0) begin
      ack_cnt++;
      chk("ack_onehot", $onehot(Ack), 1);
      chk("ack_vec", Ack, 4'b0001 << cur_id);
    end
    if (Timeout_Err) begin
      to_cnt++;
      chk("to_len", st_len_last, TO);
      chk("to_no_ack", Ack, 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    Rst = 1'b1;
    Req = '0;
    CTS = 1'b1;
    Req_Data = {8'h44, 8'hA5, 8'h22, 8'h11};
    cycles(2);
    chk_zero("rst");
    Rst = 1'b0;
    tick();

    push(2);
    Req = 4'b0100;
    wait_acks(1, 30, "single_ack");
    chk("single_st_len", st_len_last, 2);
    chk("single_req_drop", Req, 0);
    wait_idle("single_idle");

    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    tick();

    drop_on_ack = 1'b0;
    push(0); push(1); push(2); push(3); push(0);
    base = ack_cnt;
    Req = 4'b1111;
    wait_acks(base + 5, 100, "fair_acks");
    Req = '0;
    drop_on_ack = 1'b1;
    wait_idle("fair_idle");

    push(0);
    Req = 4'b0001;
    wait_acks(ack_cnt + 1, 30, "wrap_p1");
    wait_idle("wrap_idle1");
    push(3);
    Req = 4'b1000;
    wait_acks(ack_cnt + 1, 30, "wrap_g3");
    wait_idle("wrap_idle2");
    push(0); push(3);
    base = ack_cnt;
    Req = 4'b1001;
    wait_acks(base + 2, 60, "wrap_1001");
    wait_idle("wrap_idle3");

    uart_en = 1'b0;
    push(0); push(1); push(0);
    base = ack_cnt;
    Req = 4'b0011;
    wait_to(1, 40);
    chk("to_acks", ack_cnt, base);
    uart_en = 1'b1;
    wait_acks(base + 2, 60, "to_recover");
    wait_idle("to_idle");
    chk("to_cnt", to_cnt, 1);

    CTS = 1'b0;
    s = start_cnt;
    Req = 4'b0001;
    cycles(5);
    chk("cts_block", start_cnt, s);
    chk("cts_idle", Arb_Busy, 0);
    push(0);
    CTS = 1'b1;
    tick();
    chk("cts_release", Transmit_Start, 1);
    wait_acks(ack_cnt + 1, 30, "cts_ack");
    wait_idle("cts_done");

    force_busy = 1'b1;
    s = start_cnt;
    Req = 4'b0001;
    cycles(5);
    chk("txb_block", start_cnt, s);
    push(0);
    force_busy = 1'b0;
    tick();
    chk("txb_release", Transmit_Start, 1);
    wait_acks(ack_cnt + 1, 30, "txb_ack");
    wait_idle("txb_done");

    push(0);
    Req = 4'b0001;
    wait_acks(ack_cnt + 1, 30, "rst_pre_ack");
    chk("rst_in_busy", Arb_Busy, 1);
    #2;
    Rst = 1'b1;
    #1;
    chk_zero("arst");
    Req = 4'b0010;
    push(1);
    cycles(2);
    Rst = 1'b0;
    wait_acks(ack_cnt + 1, 40, "rst_regrant");
    wait_idle("rst_done");
    chk("sb_drain", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin controller that shares the single UART transmitter among `NUM_REQ` byte sources. It sits between the requesters and the UART's `Tx_Data` / `Transmit_Start` / `Tx_Busy` port. For each grant it latches the winner's byte, runs the start handshake, acknowledges the requester and waits for the frame to finish. A start that is never taken by the UART times out and is reported.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_BITS`, 8: byte width; must match the UART's `DATA_BITS`.
- `START_TIMEOUT`, 64: `Clk` cycles `Transmit_Start` may be held without `Tx_Busy` rising; ≥ 2.
- `Clk`  in  1  UART baud-domain clock; all logic on posedge.
- `Rst`  in  1  asynchronous, active-high reset.
- `Req`  in  `NUM_REQ`  per-requester byte-pending flag.
- `Req_Data`  in  `NUM_REQ*DATA_BITS`  requester k's byte at bits `[k*DATA_BITS +: DATA_BITS]`.
- `Ack`  out  `NUM_REQ`  one-hot, one-cycle pulse: requester's byte accepted by the UART.
- `CTS`  in  1  launch permitted only while high.
- `Tx_Data`  out  `DATA_BITS`  byte presented to the UART.
- `Transmit_Start`  out  1  start request to the UART.
- `Tx_Busy`  in  1  UART transmitter busy.
- `Grant_Id`  out  `$clog2(NUM_REQ)`  index of the current or last winner.
- `Arb_Busy`  out  1  high in any state other than IDLE.
- `Timeout_Err`  out  1  one-cycle pulse on a start timeout.

## Operation
- FSM states: IDLE, START, BUSY. All outputs are registered.
- **IDLE**
  - Launch condition: `CTS & !Tx_Busy & |Req`.
  - When it holds, the round-robin pick chooses the first requester with `Req` set, searching from `Rr_Ptr` upward with wrap.
  - On a pick: latch `Req_Data` slice into `Tx_Data`, load `Grant_Id`, clear the timeout counter, go to START.
- **START**
  - `Transmit_Start` = 1 throughout.
  - On `Tx_Busy` = 1: drop `Transmit_Start`, pulse `Ack[Grant_Id]`, go to BUSY.
  - Otherwise increment the counter.
  - When the counter reaches `START_TIMEOUT-1`: drop `Transmit_Start`, pulse `Timeout_Err`, no `Ack`, go to IDLE.
- **BUSY**
  - On `Tx_Busy` = 0: go to IDLE.
- `Rr_Ptr` update: set to `(Grant_Id+1) mod NUM_REQ` on leaving START, whether by success or timeout. A dead requester therefore cannot starve the others.
- Requester contract:
  - Hold `Req` high until `Ack`; drop it in the `Ack` cycle or later.
  - Data is sampled only at grant. The requester may change it after the grant.
  - `Req` falling during START/BUSY does not abort the transfer; `Ack` still pulses.
- `CTS` is checked only in IDLE. Deassertion mid-frame has no effect.
- `Tx_Busy` high in IDLE (UART driven elsewhere, e.g. BIST) blocks launch.
- Reset values: state IDLE, `Rr_Ptr`=0, `Tx_Data`=0, `Transmit_Start`=0, `Ack`=0, `Grant_Id`=0, `Arb_Busy`=0, `Timeout_Err`=0, counter=0.
- Reset mid-operation: all outputs return to reset values immediately (async). The in-flight requester is not acknowledged and must retry.

## Timing
- Launch latency: `Req` sampled high in IDLE at edge n → `Transmit_Start`, `Tx_Data`, `Grant_Id` and `Arb_Busy` valid after edge n.
- Ack latency: `Tx_Busy` sampled high at edge m → `Ack` pulse and `Transmit_Start`=0 after edge m.
- Turnaround: `Tx_Busy` sampled low at edge p → IDLE after p. The earliest next `Transmit_Start` follows edge p+1, so there is one idle cycle between frames.
- Timeout: `Transmit_Start` is high for exactly `START_TIMEOUT` cycles, then `Timeout_Err` pulses for one cycle.
- Simultaneous requests: exactly one winner per launch; ties are resolved by `Rr_Ptr` only.

## Structure
- Shared package `uart_pkg` holds:
  - `arb_state_t` enum {IDLE, START, BUSY};
  - a `localparam` for the default `START_TIMEOUT`.
- Sub-module `uart_rr_pick`: combinational, inputs `Req` and `Rr_Ptr`; outputs winner index and a valid flag. Implemented as a rotate, priority-encode, unrotate.
- Timeout counter width: `$clog2(START_TIMEOUT)`.

## Test plan
- Single request: `NUM_REQ`=4; `Req`=4'b0100 with data 8'hA5, UART model raises `Tx_Busy` 2 cycles after start → `Tx_Data`=8'hA5, `Grant_Id`=2, `Ack`=4'b0100 for one cycle, `Transmit_Start` high exactly 2 cycles.
- Fairness: `Req`=4'b1111 held through repeated grants → grant order 0,1,2,3,0; no `Ack` is ever multi-hot.
- Wrap: after a grant to 3, `Req`=4'b1001 → next grant to 0; `Rr_Ptr`=1 with `Req`=4'b0001 → grant to 0.
- Timeout: `START_TIMEOUT`=8, `Tx_Busy` stuck low → `Transmit_Start` high 8 cycles, `Timeout_Err` one pulse, no `Ack`, next grant goes to the following requester.
- Gating: `CTS`=0, or `Tx_Busy`=1 in IDLE, with `Req`=4'b0001 → no `Transmit_Start`; releasing either gate → `Transmit_Start` one cycle later.
- Async reset asserted in BUSY → all outputs 0 without a clock edge; after release, a pending `Req`=4'b0010 is granted first (`Rr_Ptr`=0, next in order).
